// File: rtl/dir_input_conditioner.sv
// rtl/dir_input_conditioner.sv - debounced one-hot direction strobes from four raw pushbuttons
module dir_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       btn_w,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic       conflict,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        FIRE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_dir;
    logic             r_conflict;
    logic [7:0]       r_press_count;

    logic [3:0]       w_sv;
    logic             w_onehot;

    assign w_sv     = r_sync2;
    assign w_onehot = (w_sv != 4'd0) && ((w_sv & (w_sv - 4'd1)) == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1       <= 4'd0;
            r_sync2       <= 4'd0;
            r_state       <= IDLE;
            r_cand        <= 4'd0;
            r_cnt         <= '0;
            r_dir         <= 4'd0;
            r_conflict    <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_sync1    <= {btn_n, btn_s, btn_e, btn_w};
            r_sync2    <= r_sync1;
            r_dir      <= 4'd0;
            r_conflict <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_cand  <= w_sv;
                        r_cnt   <= CNT_W'(1);
                        r_state <= QUALIFY;
                    end else if (w_sv != 4'd0) begin
                        r_conflict <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RELEASE;
                    end
                end
                QUALIFY: begin
                    if (w_sv == r_cand) begin
                        if (r_cnt == CNT_FULL) begin
                            // Strobe is registered on the same edge that enters FIRE.
                            r_dir         <= r_cand;
                            r_press_count <= r_press_count + 8'd1;
                            r_state       <= FIRE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_sv == 4'd0) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_conflict <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RELEASE;
                    end
                end
                FIRE: begin
                    r_cnt   <= '0;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    // Any activity restarts the all-released run; the run's final sample re-arms IDLE.
                    if (w_sv != 4'd0) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {n, s, e, w} = r_dir;
    assign conflict     = r_conflict;
    assign press_count  = r_press_count;

endmodule
